config_frame_loader: RTL and testbench
======================================

Name: config_frame_loader

Overview:
- Upstream feeder for the routing fabric's switch boxes and other 32-bit configurable tiles.
- Accepts a byte stream from the host link through a valid/ready handshake and parses framed configuration writes.
- Drives a shared 32-bit config_data bus plus a one-hot, single-cycle config_en strobe to the addressed tile.
- Tiles latch config_data when their config_en bit is high at posedge clk.

Parameters:
NUM_TARGETS, 16, number of configurable tiles; width of config_en; legal addresses 0..NUM_TARGETS-1 (max 256)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_data  input  8  stream byte from host link
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
config_data  output  32  configuration word broadcast to all tiles
config_en  output  NUM_TARGETS  one-hot write strobe, bit i = tile i
frame_count  output  16  count of frames successfully issued, wraps at 16'hFFFF->0
err_addr  output  1  sticky: frame addressed tile >= NUM_TARGETS
err_chk  output  1  sticky: checksum mismatch
err_clr  input  1  clears err_addr/err_chk
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: state=IDLE, in_ready=1, config_data=0, config_en=0, frame_count=0, err_addr=0, err_chk=0, busy=0.
- Frame format, one byte per transfer: SYNC_BYTE, ADDR, D0, D1, D2, D3, CHK.
  - Word = {D3,D2,D1,D0}; D0 is the LSB.
  - CHK = ADDR ^ D0 ^ D1 ^ D2 ^ D3.
- FSM states: IDLE, ADDR, DATA, CHK, ISSUE.
  - IDLE: on transfer with in_data==SYNC_BYTE -> ADDR; any other byte is consumed and discarded.
  - ADDR: on transfer, latch address -> DATA with byte counter=0.
  - DATA: on each transfer, shift byte into word register at position counter; at counter==3 -> CHK; otherwise counter+1.
  - CHK, on transfer:
    - running XOR != in_data: set err_chk -> IDLE.
    - address >= NUM_TARGETS: set err_addr -> IDLE.
    - otherwise -> ISSUE.
    - If both faults are present, only err_chk is set.
  - ISSUE: one cycle.
    - config_en = one-hot(address) and config_data = assembled word, both registered and presented in this same cycle.
    - frame_count+1.
    - -> IDLE.
- in_ready = 1 in IDLE/ADDR/DATA/CHK and 0 in ISSUE. No byte is accepted during the strobe cycle.
- In-frame bytes equal to SYNC_BYTE are treated as data; there is no resync mid-frame.
- Latency: config_en is high in the cycle immediately after the cycle in which the CHK byte transfers.
- config_en is high for exactly one cycle per good frame and is never multi-hot.
- config_data holds its last issued value until the next ISSUE; it is never updated on bad frames.
- Stalls: in_valid low leaves state and counters unchanged. There is no timeout.
- err_clr: clears both sticky flags. If err_clr and a new error occur in the same cycle, the set wins.
- Reset mid-frame: the partial frame is discarded, no config_en is issued, and the FSM returns to IDLE next cycle.
- Reset during ISSUE: config_en is forced 0 from the next edge and frame_count is reset to 0.

Test Plan:
- Reset, then frame A5,03,78,56,34,12,CHK=03^78^56^34^12=0x0B, with in_valid held high -> one cycle after the CHK transfer: config_en=16'h0008, config_data=32'h12345678, frame_count=1; in_ready=0 for that cycle only.
- Garbage bytes 00,FF,5A, then the frame above to addr 0 with data 0xDEADBEEF (CHK=00^EF^BE^AD^DE=0x22) -> garbage ignored, config_en=16'h0001, config_data=32'hDEADBEEF.
- Same frame with CHK=0x23 -> no config_en, err_chk=1, config_data unchanged; err_clr pulse -> err_chk=0.
- Addr 0x10 (NUM_TARGETS=16) with a correct CHK -> no strobe, err_addr=1, frame_count unchanged; the following valid frame issues normally.
- in_valid toggled randomly 50% during a frame -> identical result to the back-to-back case; the strobe is exactly one cycle.
- reset asserted after the D1 byte, then a complete frame to addr 5 -> only that frame issues: config_en=16'h0020, frame_count=1.

Source files
------------

// File: rtl/config_frame_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_frame_loader : parses SYNC/ADDR/D0..D3/CHK byte frames into one-hot
// config writes for 32-bit tiles.   Revision 1.0
// ---------------------------------------------------------------------------
module config_frame_loader #(
  parameter int unsigned NUM_TARGETS = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [31:0]            config_data,
  output logic [NUM_TARGETS-1:0] config_en,
  output logic [15:0]            frame_count,
  output logic                   err_addr,
  output logic                   err_chk,
  input  logic                   err_clr,
  output logic                   busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_ISSUE = 3'd4
  } state_t;

  state_t                 state;
  logic [7:0]             addr;
  logic [31:0]            word;
  logic [1:0]             byte_cnt;
  logic [7:0]             chk_acc;
  logic                   xfer;
  logic                   addr_ok;
  logic [NUM_TARGETS-1:0] onehot;

  assign xfer    = in_valid & in_ready;
  assign addr_ok = ({24'd0, addr} < NUM_TARGETS);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      onehot[i] = ({24'd0, addr} == 32'(i));
    end
  end

  // in_ready and busy are registered, so each transition also sets their next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= 8'd0;
      word        <= 32'd0;
      byte_cnt    <= 2'd0;
      chk_acc     <= 8'd0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      config_data <= 32'd0;
      config_en   <= '0;
      frame_count <= 16'd0;
      err_addr    <= 1'b0;
      err_chk     <= 1'b0;
    end else begin
      // Clear first so a same-cycle error set below takes priority.
      if (err_clr) begin
        err_addr <= 1'b0;
        err_chk  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (xfer && (in_data == SYNC_BYTE)) begin
            state <= ST_ADDR;
            busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (xfer) begin
            addr     <= in_data;
            chk_acc  <= in_data;
            byte_cnt <= 2'd0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            word[{byte_cnt, 3'b000} +: 8] <= in_data;
            chk_acc <= chk_acc ^ in_data;
            if (byte_cnt == 2'd3) begin
              state <= ST_CHK;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_CHK: begin
          if (xfer) begin
            if (chk_acc != in_data) begin
              err_chk <= 1'b1;
              state   <= ST_IDLE;
              busy    <= 1'b0;
            end else if (!addr_ok) begin
              err_addr <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              state       <= ST_ISSUE;
              in_ready    <= 1'b0;
              config_en   <= onehot;
              config_data <= word;
              frame_count <= frame_count + 16'd1;
            end
          end
        end
        ST_ISSUE: begin
          config_en <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          config_en <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_config_frame_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_config_frame_loader : directed self-checking bench for config_frame_loader.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_config_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic [15:0] frame_count;
  logic        err_addr;
  logic        err_chk;
  logic        err_clr;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  config_frame_loader #(.NUM_TARGETS(16), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .config_data (config_data),
    .config_en   (config_en),
    .frame_count (frame_count),
    .err_addr    (err_addr),
    .err_chk     (err_chk),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  // Presents one byte at the negedge and returns just after the posedge it transfers on.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
      end
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] w,
                            input logic [7:0] c, input bit stall);
    send_byte(8'hA5, stall);
    send_byte(a, stall);
    send_byte(w[7:0], stall);
    send_byte(w[15:8], stall);
    send_byte(w[23:16], stall);
    send_byte(w[31:24], stall);
    send_byte(c, stall);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_checks++; if (config_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", config_data); end
    n_checks++; if (config_en !== 16'd0) begin n_fail++; $display("FAIL rst_en: got %h want 0", config_en); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", frame_count); end
    n_checks++; if (err_addr !== 1'b0 || err_chk !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b%b want 00", err_addr, err_chk); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    send_frame(8'h03, 32'h12345678, 8'h0B, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0008) begin n_fail++; $display("FAIL basic_en: got %h want 0008", config_en); end
    n_checks++; if (config_data !== 32'h12345678) begin n_fail++; $display("FAIL basic_data: got %h want 12345678", config_data); end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", frame_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_issue: got %b want 0", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_issue: got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if (config_en !== 16'h0000) begin n_fail++; $display("FAIL basic_en_off: got %h want 0000", config_en); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_garbage;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL garbage_busy: got %b want 0", busy); end
    send_frame(8'h00, 32'hDEADBEEF, 8'h22, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0001) begin n_fail++; $display("FAIL garbage_en: got %h want 0001", config_en); end
    n_checks++; if (config_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL garbage_data: got %h want deadbeef", config_data); end
    n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL garbage_count: got %0d want 2", frame_count); end
  endtask

  task automatic test_bad_chk;
    send_frame(8'h00, 32'hDEADBEEF, 8'h23, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0000) begin n_fail++; $display("FAIL badchk_en: got %h want 0000", config_en); end
    n_checks++; if (err_chk !== 1'b1) begin n_fail++; $display("FAIL badchk_flag: got %b want 1", err_chk); end
    n_checks++; if (err_addr !== 1'b0) begin n_fail++; $display("FAIL badchk_addrflag: got %b want 0", err_addr); end
    n_checks++; if (config_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL badchk_data: got %h want deadbeef", config_data); end
    n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL badchk_count: got %0d want 2", frame_count); end
    @(negedge clk);
    n_checks++; if (err_chk !== 1'b1) begin n_fail++; $display("FAIL badchk_sticky: got %b want 1", err_chk); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err_chk !== 1'b0) begin n_fail++; $display("FAIL badchk_clr: got %b want 0", err_chk); end
  endtask

  task automatic test_bad_addr;
    send_frame(8'h10, 32'h00000000, 8'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0000) begin n_fail++; $display("FAIL badaddr_en: got %h want 0000", config_en); end
    n_checks++; if (err_addr !== 1'b1) begin n_fail++; $display("FAIL badaddr_flag: got %b want 1", err_addr); end
    n_checks++; if (err_chk !== 1'b0) begin n_fail++; $display("FAIL badaddr_chkflag: got %b want 0", err_chk); end
    n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL badaddr_count: got %0d want 2", frame_count); end
    // Highest legal address right after the rejected frame.
    send_frame(8'h0F, 32'hCAFEF00D, 8'hC6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h8000) begin n_fail++; $display("FAIL after_badaddr_en: got %h want 8000", config_en); end
    n_checks++; if (config_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL after_badaddr_data: got %h want cafef00d", config_data); end
    n_checks++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL after_badaddr_count: got %0d want 3", frame_count); end
    n_checks++; if (err_addr !== 1'b1) begin n_fail++; $display("FAIL badaddr_sticky: got %b want 1", err_addr); end
  endtask

  task automatic test_both_faults_and_set_wins;
    // err_clr held across the whole frame; the error set on the CHK edge must win.
    @(negedge clk);
    err_clr = 1'b1;
    send_frame(8'h20, 32'h00000000, 8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (err_chk !== 1'b1) begin n_fail++; $display("FAIL both_chk: got %b want 1", err_chk); end
    n_checks++; if (err_addr !== 1'b0) begin n_fail++; $display("FAIL both_addr: got %b want 0", err_addr); end
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err_chk !== 1'b0) begin n_fail++; $display("FAIL both_clr: got %b want 0", err_chk); end
  endtask

  task automatic test_sync_in_frame;
    send_frame(8'h07, 32'hA5A5A5A5, 8'h07, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0080) begin n_fail++; $display("FAIL syncdata_en: got %h want 0080", config_en); end
    n_checks++; if (config_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL syncdata_data: got %h want a5a5a5a5", config_data); end
    n_checks++; if (frame_count !== 16'd4) begin n_fail++; $display("FAIL syncdata_count: got %0d want 4", frame_count); end
  endtask

  task automatic test_stalls;
    int strobes;
    strobes = 0;
    fork
      send_frame(8'h03, 32'h12345678, 8'h0B, 1'b1);
      begin
        repeat (60) begin
          @(negedge clk);
          if (config_en != 16'h0000) strobes++;
        end
      end
    join_any
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0008) begin n_fail++; $display("FAIL stall_en: got %h want 0008", config_en); end
    n_checks++; if (config_data !== 32'h12345678) begin n_fail++; $display("FAIL stall_data: got %h want 12345678", config_data); end
    n_checks++; if (frame_count !== 16'd5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", frame_count); end
    wait fork;
    n_checks++; if (strobes !== 1) begin n_fail++; $display("FAIL stall_strobe_cycles: got %0d want 1", strobes); end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", frame_count); end
    send_frame(8'h05, 32'h01020304, 8'h01, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0020) begin n_fail++; $display("FAIL midrst_en: got %h want 0020", config_en); end
    n_checks++; if (config_data !== 32'h01020304) begin n_fail++; $display("FAIL midrst_data: got %h want 01020304", config_data); end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count2: got %0d want 1", frame_count); end
  endtask

  task automatic test_reset_during_issue;
    send_frame(8'h02, 32'h0BADF00D, 8'h02 ^ 8'h0D ^ 8'hF0 ^ 8'hAD ^ 8'h0B, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (config_en !== 16'h0004) begin n_fail++; $display("FAIL issuerst_en_before: got %h want 0004", config_en); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (config_en !== 16'h0000) begin n_fail++; $display("FAIL issuerst_en: got %h want 0000", config_en); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL issuerst_count: got %0d want 0", frame_count); end
    n_checks++; if (config_data !== 32'd0) begin n_fail++; $display("FAIL issuerst_data: got %h want 0", config_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL issuerst_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_bad_chk();
    test_bad_addr();
    test_both_faults_and_set_wins();
    test_sync_in_frame();
    test_stalls();
    test_reset_mid_frame();
    test_reset_during_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
